// File: rtl/fp_accum_sequencer.sv
// fp_accum_sequencer: streams N binary32 samples through an external adder,
// feeding the running sum back as operand x, and presents the final sum.
// Ports:
//   clk, rst            clock (rising) and async active-low reset
//   start, count        run request and sample count, sampled in IDLE
//   in_valid/in_ready   sample handshake, in_data = binary32 sample
//   add_x, add_y        adder operands (acc / operand registers)
//   add_result          adder result, captured after ADD_LAT hold cycles
//   out_valid/out_ready final-sum handshake, out_data = final sum
//   busy, nan_seen      not-idle flag; sticky NaN flag for the run
module fp_accum_sequencer #(
  parameter int ADD_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      add_x,
  output logic [31:0]      add_y,
  input  logic [31:0]      add_result,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             nan_seen
);

  localparam int WAIT_W =
    (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ADD,
    DONE
  } state_t;

  state_t            state, state_d;
  logic [31:0]       acc, acc_d;
  logic [31:0]       operand, operand_d;
  logic [CNT_W-1:0]  remaining, remaining_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic [31:0]       sum, sum_d;
  logic              nan, nan_d;
  logic              res_nan;

  assign res_nan = (add_result[30:23] == 8'hFF)
                && (add_result[22:0] != 23'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      operand   <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      sum       <= '0;
      nan       <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      operand   <= operand_d;
      remaining <= remaining_d;
      wait_cnt  <= wait_cnt_d;
      sum       <= sum_d;
      nan       <= nan_d;
    end
  end

  always_comb begin
    state_d     = state;
    acc_d       = acc;
    operand_d   = operand;
    remaining_d = remaining;
    wait_cnt_d  = wait_cnt;
    sum_d       = sum;
    nan_d       = nan;
    unique case (state)
      IDLE: begin
        if (start) begin
          nan_d = 1'b0;
          if (count != '0) begin
            acc_d       = 32'h0000_0000;
            remaining_d = count;
            state_d     = FETCH;
          end else begin
            sum_d   = 32'h0000_0000;
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        if (in_valid) begin
          operand_d  = in_data;
          wait_cnt_d = WAIT_W'(ADD_LAT);
          state_d    = ADD;
        end
      end
      ADD: begin
        if (wait_cnt != '0) begin
          wait_cnt_d = wait_cnt - WAIT_W'(1);
        end else begin
          acc_d       = add_result;
          remaining_d = remaining - CNT_W'(1);
          nan_d       = nan | res_nan;
          // remaining never wraps: the last add goes straight to DONE
          if (remaining == CNT_W'(1)) begin
            sum_d   = add_result;
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == FETCH);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign add_x     = acc;
  assign add_y     = operand;
  assign out_data  = sum;
  assign nan_seen  = nan;

endmodule

// File: tb/tb_fp_accum_sequencer.sv
// tb_fp_accum_sequencer: scoreboard bench for fp_accum_sequencer,
// one instance with ADD_LAT=0 and one with ADD_LAT=2.
module tb_fp_accum_sequencer;

  typedef struct {
    logic [31:0] d;
    logic        n;
  } exp_t;

  logic        clk;
  logic        rst[2];
  logic        start[2];
  logic [15:0] count[2];
  logic        in_valid[2];
  logic [31:0] in_data[2];
  logic        in_ready[2];
  logic [31:0] add_x[2];
  logic [31:0] add_y[2];
  logic [31:0] add_result[2];
  logic        out_valid[2];
  logic [31:0] out_data[2];
  logic        out_ready[2];
  logic        busy[2];
  logic        nan_seen[2];

  int n_chk;
  int n_fail;
  exp_t sb[$];
  logic [31:0] smp[$];

  function automatic logic is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) d = {b[31], 63'd0};
    else d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // reference binary32 adder (exact for the values used here)
  function automatic logic [31:0] fadd(input logic [31:0] x,
                                       input logic [31:0] y);
    if (is_nan(x) || is_nan(y)) return 32'h7FC0_0000;
    if (x[30:23] == 8'hFF) return x;
    if (y[30:23] == 8'hFF) return y;
    return r2f(f2r(x) + f2r(y));
  endfunction

  assign add_result[0] = fadd(add_x[0], add_y[0]);
  assign add_result[1] = fadd(add_x[1], add_y[1]);

  fp_accum_sequencer #(.ADD_LAT(0), .CNT_W(16)) u_lat0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .count(count[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .add_x(add_x[0]), .add_y(add_y[0]),
    .add_result(add_result[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .nan_seen(nan_seen[0])
  );

  fp_accum_sequencer #(.ADD_LAT(2), .CNT_W(16)) u_lat2 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .count(count[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .add_x(add_x[1]), .add_y(add_y[1]),
    .add_result(add_result[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .nan_seen(nan_seen[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_busy"}, 32'(busy[d]), 0);
    chk({tag, "_in_ready"}, 32'(in_ready[d]), 0);
    chk({tag, "_out_valid"}, 32'(out_valid[d]), 0);
    chk({tag, "_out_data"}, out_data[d], 0);
    chk({tag, "_nan"}, 32'(nan_seen[d]), 0);
    chk({tag, "_add_x"}, add_x[d], 0);
    chk({tag, "_add_y"}, add_y[d], 0);
  endtask

  // one run: samples from smp, gap idle cycles before each sample,
  // out_ready held low for hold DONE cycles, optional reset after
  // sample rst_at has been accepted (0 = none)
  task automatic run(input int d, input int gap, input int hold,
                     input int rst_at);
    int n;
    int lat;
    int exp_lat;
    int idx;
    int gapc;
    int win;
    int dcyc;
    bit pend;
    bit seen;
    bit done;
    bit aborted;
    bit take;
    bit fire;
    logic [31:0] macc;
    logic mnan;
    logic [31:0] cx;
    logic [31:0] cy;
    logic [31:0] hd;
    exp_t e;
    n = smp.size();
    lat = (d == 0) ? 0 : 2;
    exp_lat = (gap != 0) ? -1 : ((n == 0) ? 1 : n * (lat + 2) + 1);
    idx = 0; gapc = gap; win = 0; dcyc = 0;
    pend = 0; seen = 0; done = 0; aborted = 0;
    macc = 32'd0; mnan = 1'b0; cx = 0; cy = 0; hd = 0;
    e.d = 32'd0; e.n = 1'b0;
    foreach (smp[i]) begin
      e.d = fadd(e.d, smp[i]);
      e.n = e.n | is_nan(e.d);
    end
    sb.push_back(e);
    @(negedge clk);
    start[d] = 1'b1;
    count[d] = 16'(n);
    for (int cyc = 1; cyc <= 600 && !done; cyc++) begin
      if (idx < n) begin
        if (gapc > 0) begin
          in_valid[d] = 1'b0;
          gapc--;
        end else begin
          in_valid[d] = 1'b1;
          in_data[d] = smp[idx];
        end
      end else begin
        in_valid[d] = 1'b0;
      end
      out_ready[d] = (hold == 0) || (dcyc >= hold);
      take = in_valid[d] && in_ready[d];
      fire = out_valid[d] && out_ready[d];
      chk("rdy_extra", 32'(in_ready[d] && idx >= n), 0);
      @(posedge clk);
      #1;
      start[d] = 1'b0;
      if (fire) begin
        chk("drain_busy", 32'(busy[d]), 0);
        chk("drain_valid", 32'(out_valid[d]), 0);
        if (exp_lat >= 0 && hold == 0)
          chk("drain_cyc", 32'(cyc), 32'(exp_lat + 1));
        done = 1;
      end
      if (cyc == 1) chk("nan_clr", 32'(nan_seen[d]), 0);
      if (pend) begin
        mnan = mnan | is_nan(macc);
        chk("nan_run", 32'(nan_seen[d]), 32'(mnan));
        pend = 0;
      end
      if (take) begin
        cx = macc;
        cy = smp[idx];
        macc = fadd(macc, cy);
        idx++;
        gapc = gap;
        win = lat + 1;
        if (idx == rst_at) begin
          rst[d] = 1'b0;
          #1;
          chk_zero(d, "midrst");
          void'(sb.pop_back());
          @(negedge clk);
          rst[d] = 1'b1;
          in_valid[d] = 1'b0;
          aborted = 1;
          done = 1;
        end
      end
      if (!aborted) begin
        if (win > 0) begin
          chk("add_x", add_x[d], cx);
          chk("add_y", add_y[d], cy);
          win--;
          if (win == 0) pend = 1;
        end
        if (out_valid[d]) begin
          if (!seen) begin
            seen = 1;
            if (exp_lat >= 0) chk("latency", 32'(cyc), 32'(exp_lat));
            e = sb.pop_front();
            hd = e.d;
            chk("out_data", out_data[d], e.d);
            chk("out_nan", 32'(nan_seen[d]), 32'(e.n));
          end else begin
            chk("out_hold", out_data[d], hd);
            chk("valid_hold", 32'(busy[d]), 1);
          end
          dcyc++;
        end else if (!done) begin
          chk("busy", 32'(busy[d]), 1);
        end
        @(negedge clk);
      end
    end
    if (!done) chk("timeout", 0, 1);
    if (!aborted) chk("samples", 32'(idx), 32'(n));
    out_ready[d] = 1'b0;
    in_valid[d] = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      start[i] = 1'b0;
      count[i] = 16'd0;
      in_valid[i] = 1'b0;
      in_data[i] = 32'd0;
      out_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);

    smp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    run(0, 0, 0, 0);
    run(1, 0, 0, 0);

    smp = '{32'h3F80_0000, 32'hBF80_0000};
    run(0, 0, 0, 0);
    run(1, 0, 0, 0);

    smp = {};
    run(0, 0, 0, 0);

    smp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    run(0, 4, 5, 0);

    smp = '{32'h3F80_0000, 32'h7FC0_0000, 32'h4000_0000};
    run(0, 0, 0, 0);
    smp = '{32'h4000_0000};
    run(0, 0, 0, 0);

    smp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    run(0, 0, 0, 2);
    smp = '{32'h4000_0000};
    run(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_accum_sequencer.md
Name: fp_accum_sequencer

Overview:
- Upstream/downstream control stage wrapped around the single-precision floating-point adder.
- Accepts a stream of N IEEE-754 binary32 samples over a valid/ready handshake and sequences them through the adder one add per sample, with the running sum fed back as the other operand.
- Presents the final sum on a valid/ready output port.
- Drives the adder's x/y inputs and captures its result; the adder itself stays a separate instance.

Parameters:
- ADD_LAT, 0: extra cycles add_x/add_y are held stable before add_result is captured. 0 means a combinational adder, captured in the first ADD cycle.
- CNT_W, 16: width of the sample-count input and the internal remaining counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle run request; sampled only in IDLE.
- count  input  CNT_W  number of samples in the run, sampled with start; 0 is legal.
- in_valid  input  1  sample valid.
- in_data  input  32  sample, binary32.
- in_ready  output  1  sequencer accepts a sample this cycle.
- add_x  output  32  adder operand x, equal to the accumulator register.
- add_y  output  32  adder operand y, equal to the operand register.
- add_result  input  32  adder result.
- out_valid  output  1  final sum valid.
- out_data  output  32  final sum.
- out_ready  input  1  consumer accepts the sum.
- busy  output  1  high whenever the state is not IDLE.
- nan_seen  output  1  sticky: some captured add_result in the current run was NaN.

Behaviour:
- Reset (rst=0, asynchronous) forces the following, from any state including mid-run; no partial result is emitted:
  - state=IDLE
  - acc=0, operand=0, remaining=0, wait_cnt=0
  - out_data=0, nan_seen=0
  - in_ready=0, out_valid=0, busy=0
- All state is registered. add_x/add_y come straight from the acc/operand registers, so they are glitch-free and hold their values outside ADD.
- States: IDLE, FETCH, ADD, DONE.
- IDLE:
  - start=1 and count!=0: acc<=32'h00000000, remaining<=count, nan_seen<=0, go to FETCH.
  - start=1 and count==0: out_data<=0, nan_seen<=0, go to DONE.
- FETCH:
  - in_ready=1, combinational from state only.
  - On in_valid&&in_ready: operand<=in_data, wait_cnt<=ADD_LAT, go to ADD.
  - in_valid low: stay in FETCH indefinitely.
- ADD:
  - in_ready=0.
  - wait_cnt!=0: wait_cnt<=wait_cnt-1.
  - wait_cnt==0: acc<=add_result, remaining<=remaining-1, and nan_seen<=nan_seen|(add_result[30:23]==8'hFF && add_result[22:0]!=0).
    - remaining==1: out_data<=add_result, go to DONE.
    - Otherwise go to FETCH.
- DONE:
  - out_valid=1, out_data held stable.
  - On out_ready: go to IDLE.
  - out_valid must not drop before the handshake completes.
- start outside IDLE is ignored. The count bus is don't-care except in the start cycle of IDLE.
- Latency with in_valid held high and ADD_LAT=L: start at cycle 0, out_valid first high at cycle N*(L+2)+1. For count=0, out_valid is high at cycle 1.
- Throughput: one sample every L+2 cycles. A new run cannot start until DONE is drained.
- Arithmetic: no rounding, normalisation or special-case handling here; all of it belongs to the adder.
  - Accumulator seed is +0.0.
  - Inf/NaN pass through acc unchanged by the sequencer.
- remaining counts down to 1 and never wraps; count=2^CNT_W-1 is the largest run.

Test Plan:
- ADD_LAT=0, start count=3, samples 3F800000, 40000000, 40400000 back-to-back, out_ready=1 -> out_valid at cycle 7, out_data=40C00000 (6.0), nan_seen=0, busy low at cycle 8.
- count=2, samples 3F800000 then BF800000 -> out_data=00000000. Same run with ADD_LAT=2 -> out_valid at cycle 9, and add_x/add_y stable across each 3-cycle ADD window.
- count=0 start -> out_valid at cycle 1, out_data=0, in_ready never asserted.
- count=3, in_valid deasserted 4 cycles between samples, out_ready held low 5 cycles in DONE -> in_ready high only in FETCH, out_data stays 40C00000 until the out_ready handshake, no sample lost or duplicated.
- count=3, samples 3F800000, 7FC00000, 40000000 -> nan_seen=1 from capture of the second add onward, out_data=7FC00000. A following start clears nan_seen.
- rst pulsed low mid-ADD on sample 2 of 3 -> all outputs 0 and IDLE immediately. start again with count=1, sample 40000000 -> out_data=40000000.
